terminal_writer: RTL and testbench

//  Byte-stream to character-RAM writer for the VGA text terminal, parametrised in screen size.

---
 rtl/terminal_writer_if.sv | 30 +++
 rtl/terminal_writer.sv | 212 +++++++++++++++++++++
 tb/tb_terminal_writer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/terminal_writer_if.sv
// Byte-stream input and character-RAM write side of the VGA text terminal writer.
// master = byte source / RAM observer, slave = terminal_writer.
interface terminal_writer_if #(
  parameter int unsigned WIDTH_CHARS  = 80,
  parameter int unsigned HEIGHT_CHARS = 30
);
  localparam int unsigned ADDR_W = $clog2(WIDTH_CHARS * HEIGHT_CHARS);
  localparam int unsigned X_W    = $clog2(WIDTH_CHARS);
  localparam int unsigned Y_W    = $clog2(HEIGHT_CHARS);

  logic [7:0]        Data_i;
  logic              Valid_i;
  logic              Ready_o;
  logic              WrEnable_o;
  logic [ADDR_W-1:0] WrAddr_o;
  logic [7:0]        WrData_o;
  logic [X_W-1:0]    CursorX_o;
  logic [Y_W-1:0]    CursorY_o;
  logic [Y_W-1:0]    TopRow_o;

  modport master (
    output Data_i, Valid_i,
    input  Ready_o, WrEnable_o, WrAddr_o, WrData_o, CursorX_o, CursorY_o, TopRow_o
  );

  modport slave (
    input  Data_i, Valid_i,
    output Ready_o, WrEnable_o, WrAddr_o, WrData_o, CursorX_o, CursorY_o, TopRow_o
  );
endinterface

// File: rtl/terminal_writer.sv
// Byte-stream to character-RAM writer with cursor, control codes and ring-buffer scrolling.
// Define TERMINAL_TAB_EN to build the TAB state (0x09 blanks up to the next 8-column stop).
module terminal_writer #(
  parameter int unsigned WIDTH_CHARS  = 80,
  parameter int unsigned HEIGHT_CHARS = 30,
  parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
  input logic              Clock,
  input logic              Reset,
  terminal_writer_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(WIDTH_CHARS * HEIGHT_CHARS);
  localparam int unsigned X_W    = $clog2(WIDTH_CHARS);
  localparam int unsigned Y_W    = $clog2(HEIGHT_CHARS);

  localparam logic [X_W-1:0]    XLast    = X_W'(WIDTH_CHARS - 1);
  localparam logic [Y_W-1:0]    YLast    = Y_W'(HEIGHT_CHARS - 1);
  localparam logic [ADDR_W-1:0] CellLast = ADDR_W'(WIDTH_CHARS * HEIGHT_CHARS - 1);
  localparam logic [ADDR_W-1:0] RowLast  = ADDR_W'(WIDTH_CHARS - 1);
  localparam logic [ADDR_W-1:0] RowLen   = ADDR_W'(WIDTH_CHARS);
  localparam logic [Y_W:0]      Height   = (Y_W + 1)'(HEIGHT_CHARS);

`ifdef TERMINAL_TAB_EN
  typedef enum logic [2:0] {StClearAll, StIdle, StWrite, StClearRow, StTab} stateT;
`else
  typedef enum logic [1:0] {StClearAll, StIdle, StWrite, StClearRow} stateT;
`endif

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] cntQ, cntD;
  logic [ADDR_W-1:0] clrBaseQ, clrBaseD;
  logic              readyQ, readyD;
  logic              wrEnQ, wrEnD;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrD;
  logic [7:0]        wrDataQ, wrDataD;
  logic [X_W-1:0]    curXQ, curXD;
  logic [Y_W-1:0]    curYQ, curYD;
  logic [Y_W-1:0]    topQ, topD;

  logic isPrint, isCr, isLf, isBs, isFf;
  assign isPrint = (bus.Data_i >= 8'h20);
  assign isCr    = (bus.Data_i == 8'h0D);
  assign isLf    = (bus.Data_i == 8'h0A);
  assign isBs    = (bus.Data_i == 8'h08);
  assign isFf    = (bus.Data_i == 8'h0C);
`ifdef TERMINAL_TAB_EN
  logic isTab;
  assign isTab = (bus.Data_i == 8'h09);
`endif

  logic           wrapX, scroll;
  logic [X_W-1:0] xInc;
  logic [Y_W-1:0] topInc;
  assign wrapX  = (curXQ == XLast);
  assign scroll = (curYQ == YLast);
  assign xInc   = curXQ + X_W'(1);
  assign topInc = (topQ == YLast) ? '0 : topQ + Y_W'(1);

  // Logical row -> physical row in the ring; the sum never reaches 2*HEIGHT_CHARS.
  logic [Y_W:0]      physSum;
  logic [Y_W-1:0]    physRow;
  logic [ADDR_W-1:0] curAddr, topBase;
  assign physSum = {1'b0, topQ} + {1'b0, curYQ};
  assign physRow = (physSum >= Height) ? Y_W'(physSum - Height) : physSum[Y_W-1:0];
  assign curAddr = ADDR_W'(physRow) * RowLen + ADDR_W'(curXQ);
  assign topBase = ADDR_W'(topQ) * RowLen;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ   <= StClearAll;
      cntQ     <= '0;
      clrBaseQ <= '0;
      readyQ   <= 1'b0;
      wrEnQ    <= 1'b0;
      wrAddrQ  <= '0;
      wrDataQ  <= '0;
      curXQ    <= '0;
      curYQ    <= '0;
      topQ     <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      clrBaseQ <= clrBaseD;
      readyQ   <= readyD;
      wrEnQ    <= wrEnD;
      wrAddrQ  <= wrAddrD;
      wrDataQ  <= wrDataD;
      curXQ    <= curXD;
      curYQ    <= curYD;
      topQ     <= topD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StClearAll: if (cntQ == CellLast) stateD = StIdle;
      StIdle: begin
        if (bus.Valid_i) begin
          if (isPrint) stateD = StWrite;
          else if (isFf) stateD = StClearAll;
          else if (isLf && scroll) stateD = StClearRow;
`ifdef TERMINAL_TAB_EN
          else if (isTab) stateD = StTab;
`endif
        end
      end
      StWrite:    stateD = (wrapX && scroll) ? StClearRow : StIdle;
      StClearRow: if (cntQ == RowLast) stateD = StIdle;
`ifdef TERMINAL_TAB_EN
      StTab: begin
        if (wrapX) stateD = scroll ? StClearRow : StIdle;
        else if (xInc[2:0] == 3'd0) stateD = StIdle;
      end
`endif
      default: stateD = StClearAll;
    endcase
  end

  // Registered-output next values; nl requests a newline from the current cursor.
  logic nl;
  always_comb begin
    nl       = 1'b0;
    cntD     = cntQ;
    clrBaseD = clrBaseQ;
    curXD    = curXQ;
    curYD    = curYQ;
    topD     = topQ;
    wrEnD    = 1'b0;
    wrAddrD  = wrAddrQ;
    wrDataD  = wrDataQ;
    unique case (stateQ)
      StClearAll: begin
        wrEnD   = 1'b1;
        wrAddrD = cntQ;
        wrDataD = BLANK_CHAR;
        cntD    = (cntQ == CellLast) ? '0 : cntQ + ADDR_W'(1);
        curXD   = '0;
        curYD   = '0;
        topD    = '0;
      end
      StIdle: begin
        if (bus.Valid_i) begin
          if (isPrint) begin
            wrEnD   = 1'b1;
            wrAddrD = curAddr;
            wrDataD = bus.Data_i;
          end else if (isCr) begin
            curXD = '0;
          end else if (isLf) begin
            nl = 1'b1;
          end else if (isBs) begin
            if (curXQ != '0) curXD = curXQ - X_W'(1);
          end else if (isFf) begin
            cntD  = '0;
            curXD = '0;
            curYD = '0;
            topD  = '0;
          end
        end
      end
      StWrite: begin
        if (wrapX) begin
          curXD = '0;
          nl    = 1'b1;
        end else begin
          curXD = xInc;
        end
      end
      StClearRow: begin
        wrEnD   = 1'b1;
        wrAddrD = clrBaseQ + cntQ;
        wrDataD = BLANK_CHAR;
        cntD    = (cntQ == RowLast) ? '0 : cntQ + ADDR_W'(1);
      end
`ifdef TERMINAL_TAB_EN
      StTab: begin
        wrEnD   = 1'b1;
        wrAddrD = curAddr;
        wrDataD = BLANK_CHAR;
        if (wrapX) begin
          curXD = '0;
          nl    = 1'b1;
        end else begin
          curXD = xInc;
        end
      end
`endif
      default: ;
    endcase

    // Scrolling reuses the old top row as the new bottom row, so it is the one blanked.
    if (nl) begin
      if (scroll) begin
        topD     = topInc;
        clrBaseD = topBase;
      end else begin
        curYD = curYQ + Y_W'(1);
      end
    end

    readyD = (stateD == StIdle);
  end

  assign bus.Ready_o    = readyQ;
  assign bus.WrEnable_o = wrEnQ;
  assign bus.WrAddr_o   = wrAddrQ;
  assign bus.WrData_o   = wrDataQ;
  assign bus.CursorX_o  = curXQ;
  assign bus.CursorY_o  = curYQ;
  assign bus.TopRow_o   = topQ;
endmodule

// File: tb/tb_terminal_writer.sv
// Directed bench for terminal_writer at 80x30; checks reset, writes, control codes, scroll,
// form feed, mid-operation reset and tab handling.
module tb_terminal_writer;
  logic Clock;
  logic Reset;

  terminal_writer_if #(.WIDTH_CHARS(80), .HEIGHT_CHARS(30)) bus ();

  terminal_writer #(.WIDTH_CHARS(80), .HEIGHT_CHARS(30), .BLANK_CHAR(8'h20)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always begin
    @(posedge Clock);
    #1;
    if (Reset === 1'b1 && bus.WrEnable_o === 1'b1)
      q.push_back('{addr: bus.WrAddr_o, data: bus.WrData_o});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  function automatic int blank_errs(input int first, input int base, input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= q.size()) e++;
      else if (q[first+i].addr !== 12'(base + i) || q[first+i].data !== 8'h20) e++;
    end
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.Ready_o !== 1'b1 && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (bus.Ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: Ready_o=%b after %0d cycles, want 1", tag, bus.Ready_o, n);
    end
  endtask

  // Returns at the negedge of the cycle after the handshake.
  task automatic send(input logic [7:0] b);
    wait_ready("send");
    bus.Data_i  = b;
    bus.Valid_i = 1'b1;
    @(negedge Clock);
    bus.Valid_i = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Valid_i = 1'b0;
    bus.Data_i  = 8'h00;
    repeat (10) @(negedge Clock);
    vectors++;
    if (bus.Ready_o !== 1'b0 || bus.WrEnable_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: Ready_o=%b WrEnable_o=%b, want 0 0", bus.Ready_o, bus.WrEnable_o);
    end
    vectors++;
    if (bus.WrAddr_o !== 12'd0 || bus.WrData_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bus: WrAddr_o=%0d WrData_o=%h, want 0 00", bus.WrAddr_o, bus.WrData_o);
    end
    vectors++;
    if (bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd0 || bus.TopRow_o !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_cursor: (%0d,%0d) top %0d, want (0,0) top 0",
               bus.CursorX_o, bus.CursorY_o, bus.TopRow_o);
    end
    q.delete();
    Reset = 1'b1;
    wait_ready("clear_all");
    vectors++;
    if (q.size() != 2400 || blank_errs(0, 0, 2400) != 0) begin
      miscompares++;
      $display("FAIL clear_all: %0d strobes, %0d bad, want 2400 0", q.size(), blank_errs(0, 0, 2400));
    end
    vectors++;
    if (bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd0 || bus.TopRow_o !== 5'd0) begin
      miscompares++;
      $display("FAIL clear_all_cursor: (%0d,%0d) top %0d, want (0,0) top 0",
               bus.CursorX_o, bus.CursorY_o, bus.TopRow_o);
    end
  endtask

  task automatic test_print();
    send(8'h41);
    vectors++;
    if (bus.WrEnable_o !== 1'b1 || bus.WrAddr_o !== 12'd0 || bus.WrData_o !== 8'h41) begin
      miscompares++;
      $display("FAIL print_a: en %b %h@%0d, want 1 41@0", bus.WrEnable_o, bus.WrData_o, bus.WrAddr_o);
    end
    vectors++;
    if (bus.Ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL print_busy: Ready_o=%b, want 0", bus.Ready_o);
    end
    @(negedge Clock);
    vectors++;
    if (bus.Ready_o !== 1'b1 || bus.CursorX_o !== 7'd1) begin
      miscompares++;
      $display("FAIL print_adv: Ready_o=%b X=%0d, want 1 1", bus.Ready_o, bus.CursorX_o);
    end
    send(8'h42);
    vectors++;
    if (bus.WrEnable_o !== 1'b1 || bus.WrAddr_o !== 12'd1 || bus.WrData_o !== 8'h42) begin
      miscompares++;
      $display("FAIL print_b: en %b %h@%0d, want 1 42@1", bus.WrEnable_o, bus.WrData_o, bus.WrAddr_o);
    end
    @(negedge Clock);
    vectors++;
    if (bus.CursorX_o !== 7'd2 || bus.CursorY_o !== 5'd0) begin
      miscompares++;
      $display("FAIL print_x: (%0d,%0d), want (2,0)", bus.CursorX_o, bus.CursorY_o);
    end
  endtask

  task automatic test_control();
    send(8'h43);
    send(8'h44);
    send(8'h45);
    wait_ready("ctrl_setup");
    q.delete();
    send(8'h0D);
    vectors++;
    if (bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd0 || bus.Ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ctrl_cr: (%0d,%0d) rdy %b, want (0,0) 1", bus.CursorX_o, bus.CursorY_o, bus.Ready_o);
    end
    send(8'h0A);
    vectors++;
    if (bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd1 || bus.Ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ctrl_lf: (%0d,%0d) rdy %b, want (0,1) 1", bus.CursorX_o, bus.CursorY_o, bus.Ready_o);
    end
    send(8'h08);
    vectors++;
    if (bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd1) begin
      miscompares++;
      $display("FAIL ctrl_bs: (%0d,%0d), want (0,1)", bus.CursorX_o, bus.CursorY_o);
    end
    @(negedge Clock);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL ctrl_nowrite: %0d strobes, want 0", q.size());
    end
  endtask

  task automatic test_scroll();
    repeat (28) send(8'h0A);
    repeat (79) send(8'h78);
    wait_ready("scroll_setup");
    vectors++;
    if (bus.CursorX_o !== 7'd79 || bus.CursorY_o !== 5'd29 || bus.TopRow_o !== 5'd0) begin
      miscompares++;
      $display("FAIL scroll_setup: (%0d,%0d) top %0d, want (79,29) top 0",
               bus.CursorX_o, bus.CursorY_o, bus.TopRow_o);
    end
    q.delete();
    send(8'h5A);
    vectors++;
    if (bus.WrEnable_o !== 1'b1 || bus.WrAddr_o !== 12'd2399 || bus.WrData_o !== 8'h5A) begin
      miscompares++;
      $display("FAIL scroll_z: en %b %h@%0d, want 1 5a@2399", bus.WrEnable_o, bus.WrData_o, bus.WrAddr_o);
    end
    @(negedge Clock);
    vectors++;
    if (bus.TopRow_o !== 5'd1 || bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd29) begin
      miscompares++;
      $display("FAIL scroll_top: (%0d,%0d) top %0d, want (0,29) top 1",
               bus.CursorX_o, bus.CursorY_o, bus.TopRow_o);
    end
    wait_ready("scroll_clear");
    vectors++;
    if (q.size() != 81 || blank_errs(1, 0, 80) != 0) begin
      miscompares++;
      $display("FAIL scroll_blank: %0d strobes, %0d bad, want 81 0", q.size(), blank_errs(1, 0, 80));
    end
    send(8'h51);
    vectors++;
    if (bus.WrEnable_o !== 1'b1 || bus.WrAddr_o !== 12'd0 || bus.WrData_o !== 8'h51) begin
      miscompares++;
      $display("FAIL scroll_q: en %b %h@%0d, want 1 51@0", bus.WrEnable_o, bus.WrData_o, bus.WrAddr_o);
    end
  endtask

  task automatic test_formfeed();
    int n = 0;
    wait_ready("ff_setup");
    q.delete();
    bus.Data_i  = 8'h0C;
    bus.Valid_i = 1'b1;
    @(negedge Clock);
    bus.Data_i = 8'h4D;
    vectors++;
    if (bus.Ready_o !== 1'b0 || bus.CursorX_o !== 7'd0 || bus.CursorY_o !== 5'd0 ||
        bus.TopRow_o !== 5'd0) begin
      miscompares++;
      $display("FAIL ff_enter: rdy %b (%0d,%0d) top %0d, want 0 (0,0) top 0",
               bus.Ready_o, bus.CursorX_o, bus.CursorY_o, bus.TopRow_o);
    end
    while (bus.Ready_o !== 1'b1 && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    bus.Valid_i = 1'b0;
    vectors++;
    if (q.size() != 2400 || blank_errs(0, 0, 2400) != 0) begin
      miscompares++;
      $display("FAIL ff_clear: %0d strobes, %0d bad, want 2400 0", q.size(), blank_errs(0, 0, 2400));
    end
    repeat (3) @(negedge Clock);
    vectors++;
    if (q.size() != 2400 || bus.CursorX_o !== 7'd0) begin
      miscompares++;
      $display("FAIL ff_held_valid: %0d strobes X=%0d, want 2400 0", q.size(), bus.CursorX_o);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h61);
    send(8'h62);
    send(8'h63);
    Reset = 1'b0;
    #1;
    vectors++;
    if (bus.WrEnable_o !== 1'b0 || bus.Ready_o !== 1'b0 || bus.CursorX_o !== 7'd0 ||
        bus.WrAddr_o !== 12'd0 || bus.WrData_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: en %b rdy %b X=%0d %h@%0d, want 0 0 0 00@0",
               bus.WrEnable_o, bus.Ready_o, bus.CursorX_o, bus.WrData_o, bus.WrAddr_o);
    end
    @(negedge Clock);
    q.delete();
    Reset = 1'b1;
    wait_ready("reset_mid_clear");
    vectors++;
    if (q.size() != 2400 || blank_errs(0, 0, 2400) != 0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: %0d strobes, %0d bad, want 2400 0",
               q.size(), blank_errs(0, 0, 2400));
    end
  endtask

  task automatic test_tab();
    send(8'h0A);
    send(8'h0A);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    wait_ready("tab_setup");
    vectors++;
    if (bus.CursorX_o !== 7'd3 || bus.CursorY_o !== 5'd2) begin
      miscompares++;
      $display("FAIL tab_setup: (%0d,%0d), want (3,2)", bus.CursorX_o, bus.CursorY_o);
    end
    q.delete();
    send(8'h09);
    wait_ready("tab");
`ifdef TERMINAL_TAB_EN
    vectors++;
    if (q.size() != 5 || blank_errs(0, 163, 5) != 0 || bus.CursorX_o !== 7'd8) begin
      miscompares++;
      $display("FAIL tab_on: %0d strobes, %0d bad, X=%0d, want 5 0 8",
               q.size(), blank_errs(0, 163, 5), bus.CursorX_o);
    end
`else
    vectors++;
    if (q.size() != 0 || bus.CursorX_o !== 7'd3) begin
      miscompares++;
      $display("FAIL tab_off: %0d strobes X=%0d, want 0 3", q.size(), bus.CursorX_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_print();
    test_control();
    test_scroll();
    test_formfeed();
    test_reset_mid();
    test_tab();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
